// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone instruction/data memory arbiter:
// FSM state encodings, owner codes and the default watchdog depth.
package wb_arb_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_I = 2'b01;
    localparam logic [1:0] GNT_D = 2'b10;
    localparam logic [1:0] TOUT  = 2'b11;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall counter for the arbiter: pulses expire_o on the strobed cycle
// that would make TIMEOUT cycles without ack/err.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + 1'b1;
    end

    assign expire_o = inc_i & ~clr_i & (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone classic arbiter (fetch + load/store) onto one slave.
// Optional watchdog with TOUT state when WB_ARB_TIMEOUT_EN is defined.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_addr_i,
    input  logic [DW/8-1:0] i_sel_i,
    input  logic            i_cyc_i,
    input  logic            i_stb_i,
    output logic [DW-1:0]   i_dat_o,
    output logic            i_ack_o,
    output logic            i_err_o,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_dat_i,
    input  logic [DW/8-1:0] d_sel_i,
    input  logic            d_we_i,
    input  logic            d_cyc_i,
    input  logic            d_stb_i,
    output logic [DW-1:0]   d_dat_o,
    output logic            d_ack_o,
    output logic            d_err_o,
    output logic [AW-1:0]   m_addr_o,
    output logic [DW-1:0]   m_dat_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic            m_we_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    input  logic [DW-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_err_i,
    output logic [1:0]      grant_o
);

    logic [1:0] state_q, state_d;
    logic [1:0] last_q, last_d;
    logic       req_i, req_d;
    logic       gnt_i, gnt_d;
    logic       stb_inc;
    logic       expire;

    assign req_i   = i_cyc_i & i_stb_i;
    assign req_d   = d_cyc_i & d_stb_i;
    assign gnt_i   = (state_q == GNT_I);
    assign gnt_d   = (state_q == GNT_D);
    assign stb_inc = (gnt_i & i_stb_i) | (gnt_d & d_stb_i);

    assign i_dat_o = m_dat_i;
    assign d_dat_o = m_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic [1:0] tout_own_q, tout_own_d;

    wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (~(gnt_i | gnt_d) | m_ack_i | m_err_i),
        .inc_i    (stb_inc),
        .expire_o (expire)
    );

    // Remember who timed out so TOUT can watch that master's cyc.
    always_comb begin
        tout_own_d = tout_own_q;
        if (gnt_i)
            tout_own_d = OWN_I;
        else if (gnt_d)
            tout_own_d = OWN_D;
    end

    always_ff @(posedge clk) begin
        if (rst)
            tout_own_q <= OWN_NONE;
        else
            tout_own_q <= tout_own_d;
    end
`else
    logic unused_inc;
    assign unused_inc = stb_inc;
    assign expire     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req_i && req_d)
                    state_d = (last_q == OWN_I) ? GNT_D : GNT_I;
                else if (req_i)
                    state_d = GNT_I;
                else if (req_d)
                    state_d = GNT_D;
            end
            GNT_I: begin
                if (!i_cyc_i) begin
                    state_d = IDLE;
                    last_d  = OWN_I;
                end else if (expire) begin
                    state_d = TOUT;
                end
            end
            GNT_D: begin
                if (!d_cyc_i) begin
                    state_d = IDLE;
                    last_d  = OWN_D;
                end else if (expire) begin
                    state_d = TOUT;
                end
            end
            default: begin
`ifdef WB_ARB_TIMEOUT_EN
                if ((tout_own_q == OWN_I && !i_cyc_i) ||
                    (tout_own_q == OWN_D && !d_cyc_i)) begin
                    state_d = IDLE;
                    last_d  = tout_own_q;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    always_comb begin
        m_addr_o = '0;
        m_dat_o  = '0;
        m_sel_o  = '0;
        m_we_o   = 1'b0;
        m_cyc_o  = 1'b0;
        m_stb_o  = 1'b0;
        i_ack_o  = 1'b0;
        i_err_o  = 1'b0;
        d_ack_o  = 1'b0;
        d_err_o  = 1'b0;
        grant_o  = OWN_NONE;
        if (gnt_i) begin
            m_addr_o = i_addr_i;
            m_sel_o  = i_sel_i;
            m_cyc_o  = i_cyc_i;
            m_stb_o  = i_stb_i;
            i_err_o  = m_err_i | expire;
            i_ack_o  = m_ack_i & ~m_err_i & ~expire;
            grant_o  = OWN_I;
        end else if (gnt_d) begin
            m_addr_o = d_addr_i;
            m_dat_o  = d_dat_i;
            m_sel_o  = d_sel_i;
            m_we_o   = d_we_i;
            m_cyc_o  = d_cyc_i;
            m_stb_o  = d_stb_i;
            d_err_o  = m_err_i | expire;
            d_ack_o  = m_ack_i & ~m_err_i & ~expire;
            grant_o  = OWN_D;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (state_q == TOUT) begin
            grant_o = tout_own_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= OWN_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed self-checking bench for wb_mem_arbiter (default build and,
// when compiled with WB_ARB_TIMEOUT_EN, the watchdog expiry case).
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr_i;
    logic [3:0]  i_sel_i;
    logic        i_cyc_i, i_stb_i;
    logic [31:0] i_dat_o;
    logic        i_ack_o, i_err_o;
    logic [31:0] d_addr_i, d_dat_i;
    logic [3:0]  d_sel_i;
    logic        d_we_i, d_cyc_i, d_stb_i;
    logic [31:0] d_dat_o;
    logic        d_ack_o, d_err_o;
    logic [31:0] m_addr_o, m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i, m_err_i;
    logic [1:0]  grant_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .i_addr_i(i_addr_i), .i_sel_i(i_sel_i),
        .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
        .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
        .d_addr_i(d_addr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i),
        .d_we_i(d_we_i), .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
        .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
        .m_addr_o(m_addr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .grant_o(grant_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int err_cyc;
        int cyc_lost;

        rst = 1'b1;
        i_addr_i = '0; i_sel_i = '0; i_cyc_i = 0; i_stb_i = 0;
        d_addr_i = '0; d_dat_i = '0; d_sel_i = '0;
        d_we_i = 0; d_cyc_i = 0; d_stb_i = 0;
        m_dat_i = '0; m_ack_i = 0; m_err_i = 0;
        @(negedge clk);
        step();
        rst = 1'b0;
        settle();
        check("rst_grant", grant_o, 2'b00);
        check("rst_cyc", m_cyc_o, 1'b0);
        check("rst_addr", m_addr_o, 32'h0);
        check("rst_acks", {i_ack_o, i_err_o, d_ack_o, d_err_o}, 4'b0);

        // Instruction-only read of 0x100
        i_addr_i = 32'h100; i_sel_i = 4'hf; i_cyc_i = 1; i_stb_i = 1;
        step(); settle();
        check("i_grant", grant_o, 2'b01);
        check("i_addr", m_addr_o, 32'h100);
        check("i_cyc", m_cyc_o, 1'b1);
        check("i_we", m_we_o, 1'b0);
        step();
        m_dat_i = 32'h33; m_ack_i = 1; settle();
        check("i_ack", i_ack_o, 1'b1);
        check("i_dat", i_dat_o, 32'h33);
        check("i_dack", d_ack_o, 1'b0);
        step();
        m_ack_i = 0; i_cyc_i = 0; i_stb_i = 0; settle();
        check("i_ack_1cyc", i_ack_o, 1'b0);
        step(); settle();
        check("i_release", grant_o, 2'b00);

        // Fresh reset so the next contention is the first one
        rst = 1; step(); rst = 0;

        i_addr_i = 32'h104; i_cyc_i = 1; i_stb_i = 1;
        d_addr_i = 32'h200; d_dat_i = 32'hdeadbeef; d_sel_i = 4'hf;
        d_we_i = 1; d_cyc_i = 1; d_stb_i = 1;
        step(); settle();
        check("c1_grant", grant_o, 2'b10);
        check("c1_addr", m_addr_o, 32'h200);
        check("c1_we", m_we_o, 1'b1);
        check("c1_dat", m_dat_o, 32'hdeadbeef);
        check("c1_sel", m_sel_o, 4'hf);
        m_ack_i = 1; settle();
        check("c1_dack", d_ack_o, 1'b1);
        check("c1_iack", i_ack_o, 1'b0);
        m_ack_i = 0; d_cyc_i = 0; d_stb_i = 0;
        step(); settle();
        check("c1_idle_gap", grant_o, 2'b00);
        // Data re-requests during the gap: second contention
        d_addr_i = 32'h204; d_we_i = 0; d_cyc_i = 1; d_stb_i = 1;
        step(); settle();
        check("c2_grant", grant_o, 2'b01);
        check("c2_addr", m_addr_o, 32'h104);
        check("c2_we", m_we_o, 1'b0);
        step(); settle();
        check("c2_hold", m_addr_o, 32'h104);
        m_ack_i = 1; m_dat_i = 32'h55; settle();
        check("c2_iack", i_ack_o, 1'b1);
        check("c2_ddat_bcast", d_dat_o, 32'h55);
        check("c2_dack", d_ack_o, 1'b0);
        m_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
        step(); settle();
        check("c2_idle", grant_o, 2'b00);
        check("c2_idle_cyc", m_cyc_o, 1'b0);
        step(); settle();
        check("c3_grant", grant_o, 2'b10);
        check("c3_addr", m_addr_o, 32'h204);

        // Instr requests while data owns the bus
        i_addr_i = 32'h300; i_cyc_i = 1; i_stb_i = 1;
        step(); settle();
        check("wait_grant", grant_o, 2'b10);
        check("wait_addr", m_addr_o, 32'h204);
        d_stb_i = 0;
        step(); settle();
        check("beat_gap_stb", m_stb_o, 1'b0);
        check("beat_gap_grant", grant_o, 2'b10);
        d_stb_i = 1; settle();
        m_ack_i = 1; m_err_i = 1; settle();
        check("ackerr_err", d_err_o, 1'b1);
        check("ackerr_ack", d_ack_o, 1'b0);
        check("ackerr_ierr", i_err_o, 1'b0);
        m_err_i = 0;

        // Reset mid-transfer with ack held
        rst = 1; step(); rst = 0; settle();
        check("rst_mid_cyc", m_cyc_o, 1'b0);
        check("rst_mid_grant", grant_o, 2'b00);
        check("rst_mid_dack", d_ack_o, 1'b0);
        m_ack_i = 0;
        step(); settle();
        check("rst_then_d", grant_o, 2'b10);

        // Abort: owner drops cyc without ack
        d_cyc_i = 0; d_stb_i = 0; i_cyc_i = 0; i_stb_i = 0;
        step(); settle();
        check("abort_grant", grant_o, 2'b00);
        check("abort_derr", d_err_o, 1'b0);

        // Silent slave
        i_addr_i = 32'h400; i_cyc_i = 1; i_stb_i = 1;
        err_cyc = 0;
        cyc_lost = 0;
        for (int n = 1; n <= 200; n++) begin
            step(); settle();
            if (i_err_o && err_cyc == 0) err_cyc = n;
            if (err_cyc == 0 && !m_cyc_o) cyc_lost = n;
        end
`ifdef WB_ARB_TIMEOUT_EN
        check("tout_err_cycle", err_cyc, 64);
        check("tout_cyc_lost", cyc_lost, 0);
        check("tout_cyc_low", m_cyc_o, 1'b0);
        check("tout_grant", grant_o, 2'b01);
        i_cyc_i = 0; i_stb_i = 0;
        step(); settle();
        check("tout_release", grant_o, 2'b00);
`else
        check("noto_err", err_cyc, 0);
        check("noto_cyc_lost", cyc_lost, 0);
        check("noto_cyc", m_cyc_o, 1'b1);
        check("noto_grant", grant_o, 2'b01);
        i_cyc_i = 0; i_stb_i = 0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
